// File: rtl/usr_pkg.sv
// Shared opcodes, FSM state type and exit-bit helper for the universal shift register.
package usr_pkg;

    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_SLL   = 3'b011;
    localparam logic [2:0] OP_SRL   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_ASR   = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_STEP = 1'b1
    } state_e;

    // Left-moving ops push out the MSB, right-moving ops push out the LSB.
    function automatic logic exit_bit(input logic [2:0] op, input logic msb, input logic lsb);
        logic b;
        b = 1'b0;
        case (op)
            OP_SLL, OP_ROL:         b = msb;
            OP_SRL, OP_ROR, OP_ASR: b = lsb;
            default:                b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/usr_step.sv
// One-step combinational shift/rotate unit: next register value and the bit leaving it.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_next_o,
    output logic             bit_out_o
);

    always_comb begin
        q_next_o = q_i;
        case (op_i)
            OP_SLL:  q_next_o = {q_i[WIDTH-2:0], sin_i};
            OP_SRL:  q_next_o = {sin_i, q_i[WIDTH-1:1]};
            OP_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            OP_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            OP_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            default: q_next_o = q_i;
        endcase
    end

    assign bit_out_o = exit_bit(op_i, q_i[WIDTH-1], q_i[0]);

endmodule

// File: rtl/univ_shift_reg.sv
// Universal register: single-cycle load/clear plus multi-cycle shift/rotate commands
// executed one bit per clock, with busy/done handshake and serial in/out.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [CNT_W-1:0] amt_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2:0]         op_q, op_d;
    logic               sout_q, sout_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   step_q_next;
    logic               step_bit;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .op_i      (op_q),
        .q_i       (q_q),
        .sin_i     (sin_i),
        .q_next_o  (step_q_next),
        .bit_out_o (step_bit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            q_q     <= RESET_VAL;
            count_q <= '0;
            op_q    <= OP_HOLD;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            count_q <= count_d;
            op_q    <= op_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        count_d = count_q;
        op_d    = op_q;
        sout_d  = sout_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    case (op_i)
                        OP_HOLD:  done_d = 1'b1;
                        OP_LOAD: begin
                            q_d    = d_i;
                            done_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            q_d    = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            // A zero-length shift completes immediately without entering STEP.
                            if (amt_i == '0) begin
                                done_d = 1'b1;
                            end else begin
                                op_d    = op_i;
                                count_d = amt_i;
                                state_d = ST_STEP;
                            end
                        end
                    endcase
                end else if (ld_i) begin
                    q_d = d_i;
                end
            end

            ST_STEP: begin
                q_d     = step_q_next;
                sout_d  = step_bit;
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign q_o    = q_q;
    assign sout_o = sout_q;
    assign busy_o = (state_q == ST_STEP);
    assign done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4): vector table, hand
// sequences for multi-cycle corners, and randomized commands against an arithmetic model.
module tb_univ_shift_reg;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    int mq;
    int msout;

    univ_shift_reg #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .RESET_VAL (8'h00)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .ld_i    (ld),
        .d_i     (d),
        .start_i (start),
        .op_i    (op),
        .amt_i   (amt),
        .sin_i   (sin),
        .q_o     (q),
        .sout_o  (sout),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One step computed with plain integer arithmetic on the 8-bit value.
    task automatic model_step(input logic [2:0] o, input int s);
        int nq;
        int ob;
        nq = mq;
        ob = 0;
        case (o)
            OP_SLL: begin nq = (mq * 2 + s) % 256;          ob = mq / 128; end
            OP_SRL: begin nq = mq / 2 + s * 128;            ob = mq % 2;   end
            OP_ROL: begin nq = (mq * 2) % 256 + mq / 128;   ob = mq / 128; end
            OP_ROR: begin nq = mq / 2 + (mq % 2) * 128;     ob = mq % 2;   end
            OP_ASR: begin nq = mq / 2 + ((mq >= 128) ? 128 : 0); ob = mq % 2; end
            default: begin nq = mq; ob = msout; end
        endcase
        mq    = nq;
        msout = ob;
    endtask

    task automatic ld_val(input logic [7:0] v);
        ld = 1'b1;
        d  = v;
        @(negedge clk);
        ld = 1'b0;
        mq = v;
        chk("ld_q", q, v);
        chk("ld_no_done", done, 0);
    endtask

    task automatic idle_cycle();
        logic [7:0] dv;
        logic       l;
        dv    = 8'($urandom);
        l     = 1'($urandom);
        start = 1'b0;
        ld    = l;
        d     = dv;
        @(negedge clk);
        ld = 1'b0;
        if (l) mq = dv;
        chk("idle_q", q, mq);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_sout", sout, msout);
    endtask

    // Issues a command at the current negedge (may be the done cycle of the previous one).
    task automatic do_cmd(input logic [2:0] o, input logic [3:0] a, input bit noise);
        logic [7:0] dv;
        int         s;
        dv    = 8'($urandom);
        start = 1'b1;
        op    = o;
        amt   = a;
        d     = dv;
        ld    = 1'($urandom);
        sin   = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
        ld    = 1'b0;
        if (o >= OP_SLL && a != 0) begin
            chk("e0_busy", busy, 1);
            chk("e0_done", done, 0);
            chk("e0_q", q, mq);
            for (int i = 1; i <= int'(a); i++) begin
                s   = int'($urandom_range(0, 1));
                sin = s[0];
                if (noise) begin
                    start = 1'($urandom);
                    ld    = 1'($urandom);
                    op    = 3'($urandom);
                    amt   = 4'($urandom);
                    d     = 8'($urandom);
                end
                model_step(o, s);
                @(negedge clk);
                chk("step_q", q, mq);
                chk("step_sout", sout, msout);
                chk("step_busy", busy, (i < int'(a)) ? 1 : 0);
                chk("step_done", done, (i == int'(a)) ? 1 : 0);
            end
            start = 1'b0;
            ld    = 1'b0;
        end else begin
            if (o == OP_LOAD)  mq = dv;
            if (o == OP_CLEAR) mq = 0;
            chk("imm_q", q, mq);
            chk("imm_sout", sout, msout);
            chk("imm_busy", busy, 0);
            chk("imm_done", done, 1);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] amt;
        logic [7:0] init;
        logic       sin;
        logic [7:0] exp_q;
        logic       exp_sout;
        bit         chk_sout;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{OP_ROR, 4'd1,  8'h01, 1'b0, 8'h80, 1'b1, 1};
        tbl[1] = '{OP_ROL, 4'd8,  8'h3C, 1'b0, 8'h3C, 1'b0, 1};
        tbl[2] = '{OP_ASR, 4'd2,  8'h90, 1'b1, 8'hE4, 1'b0, 1};
        tbl[3] = '{OP_SLL, 4'd3,  8'hA5, 1'b1, 8'h2F, 1'b1, 1};
        tbl[4] = '{OP_SRL, 4'd0,  8'h5A, 1'b1, 8'h5A, 1'b0, 0};
        tbl[5] = '{OP_SRL, 4'd10, 8'h81, 1'b1, 8'hFF, 1'b1, 1};
        tbl[6] = '{OP_ASR, 4'd15, 8'h40, 1'b1, 8'h00, 1'b0, 1};
        tbl[7] = '{OP_ASR, 4'd15, 8'h80, 1'b0, 8'hFF, 1'b1, 1};
        tbl[8] = '{OP_ROR, 4'd9,  8'h01, 1'b0, 8'h80, 1'b1, 1};
        tbl[9] = '{OP_SLL, 4'd4,  8'hFF, 1'b0, 8'hF0, 1'b1, 1};

        rst_n = 1'b0;
        ld = 0; d = 0; start = 0; op = 0; amt = 0; sin = 0;
        mq = 0; msout = 0;

        // Reset values visible before any clock edge.
        #2;
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sout", sout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_q", q, 0);

        // Legacy load, then start beats ld.
        ld_val(8'hA5);
        ld = 1'b1; d = 8'h77; start = 1'b1; op = OP_CLEAR; amt = 0;
        @(negedge clk);
        ld = 1'b0; start = 1'b0;
        chk("prio_q", q, 8'h00);
        chk("prio_done", done, 1);

        // SLL by 3 with intermediate values, a start during busy, then back-to-back ROR.
        ld_val(8'hA5);
        start = 1'b1; op = OP_SLL; amt = 4'd3; sin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("sll_e0_q", q, 8'hA5);
        chk("sll_e0_busy", busy, 1);
        @(negedge clk);
        chk("sll_e1_q", q, 8'h4B);
        chk("sll_e1_busy", busy, 1);
        start = 1'b1; op = OP_CLEAR; ld = 1'b1; d = 8'h00;
        @(negedge clk);
        start = 1'b0; ld = 1'b0; op = OP_SLL;
        chk("sll_e2_q", q, 8'h97);
        chk("sll_e2_busy", busy, 1);
        chk("sll_e2_done", done, 0);
        @(negedge clk);
        chk("sll_e3_q", q, 8'h2F);
        chk("sll_e3_busy", busy, 0);
        chk("sll_e3_done", done, 1);
        chk("sll_e3_sout", sout, 1);
        start = 1'b1; op = OP_ROR; amt = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done", done, 0);
        @(negedge clk);
        chk("b2b_q", q, 8'h97);
        chk("b2b_done2", done, 1);
        chk("b2b_sout", sout, 1);
        @(negedge clk);
        chk("b2b_done_clr", done, 0);

        // amt=0 shift: immediate done, busy never high.
        ld_val(8'h3C);
        start = 1'b1; op = OP_SRL; amt = 4'd0;
        @(negedge clk);
        start = 1'b0;
        chk("amt0_q", q, 8'h3C);
        chk("amt0_busy", busy, 0);
        chk("amt0_done", done, 1);
        @(negedge clk);
        chk("amt0_busy2", busy, 0);
        chk("amt0_done2", done, 0);

        // Vector table.
        for (int t = 0; t < 10; t++) begin
            bit seen;
            ld_val(tbl[t].init);
            start = 1'b1; op = tbl[t].op; amt = tbl[t].amt; sin = tbl[t].sin;
            @(negedge clk);
            start = 1'b0;
            seen = 0;
            for (int c = 0; c < 40 && !seen; c++) begin
                if (done) seen = 1;
                else @(negedge clk);
            end
            chk($sformatf("tbl%0d_done", t), seen, 1);
            chk($sformatf("tbl%0d_q", t), q, tbl[t].exp_q);
            if (tbl[t].chk_sout) chk($sformatf("tbl%0d_sout", t), sout, tbl[t].exp_sout);
            @(negedge clk);
        end

        // Reset in the middle of an SLL.
        ld_val(8'hFF);
        start = 1'b1; op = OP_SLL; amt = 4'd5; sin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_e2_q", q, 8'hFC);
        chk("mid_e2_sout", sout, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_sout", sout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mq = 0; msout = 0;
        @(negedge clk);
        chk("mid_rel_busy", busy, 0);
        do_cmd(OP_LOAD, 4'd0, 0);
        do_cmd(OP_ROL, 4'd3, 0);

        // Randomized commands against the model.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 2) == 0) idle_cycle();
            do_cmd(3'($urandom), 4'($urandom), 1'($urandom));
        end
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register; successor to the team's 8-bit load-enable register.
- Keeps the single-cycle parallel-load path (ld/d).
- Adds command-driven multi-cycle operations: clear, logical shifts, rotates and arithmetic shift, one bit per cycle.
- Provides busy/done handshake and a serial in/out pair.
- Sits in datapaths as an operand/accumulator register feeding shift-based arithmetic and serialisers.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of shift-amount field; max steps per command = 2^CNT_W-1
RESET_VAL, 0, value loaded into q on reset (WIDTH bits)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
ld  input  1  legacy parallel load; honoured only when idle and start=0
d  input  WIDTH  parallel load data (used by ld and OP_LOAD)
start  input  1  command strobe; sampled when busy=0
op  input  3  command opcode, sampled with start
amt  input  CNT_W  step count for shift/rotate ops, sampled with start
sin  input  1  serial input for logical shifts, sampled on every step edge
q  output  WIDTH  register contents
sout  output  1  registered copy of the bit most recently shifted/rotated out
busy  output  1  high while a multi-step command is executing
done  output  1  one-cycle pulse on completion of any start-initiated command

Behaviour:
- Reset (reset=0, async):
  - q=RESET_VAL, sout=0, busy=0, done=0, FSM=IDLE.
  - Holds regardless of clk; takes effect immediately mid-operation and aborts any command.
- Opcodes:
  - 000 HOLD
  - 001 LOAD (q<=d)
  - 010 CLEAR (q<=0)
  - 011 SLL (q<={q[W-2:0],sin})
  - 100 SRL (q<={sin,q[W-1:1]})
  - 101 ROL
  - 110 ROR
  - 111 ASR (MSB replicated; sin ignored)
- FSM states: IDLE, STEP.
- IDLE, start=1:
  - HOLD/LOAD/CLEAR: effect at the sampling edge E0; done=1 for the cycle after E0; busy stays 0.
  - Shift ops with amt=0: q unchanged; done pulses after E0; busy stays 0.
  - Shift ops with amt=N>=1: at E0 latch op and count=N; busy=1; go to STEP. q unchanged at E0.
- STEP:
  - Each edge E1..EN performs one step, sets sout to the exiting bit (q[W-1] for SLL/ROL, q[0] for SRL/ROR/ASR), and decrements count.
  - At EN: busy=0, done=1 for one cycle, return to IDLE.
- Latency: shift commands complete N cycles after E0; total N+1 edges from the start edge.
- Priority and ignored inputs:
  - In IDLE, start has priority over ld; if both are 1, ld is ignored.
  - ld=1 with start=0 in IDLE: q<=d at that edge; no done pulse; busy unaffected.
  - start, ld, op, amt and d are ignored while busy=1, with no queuing.
  - start may be re-asserted in the cycle done is high (back-to-back commands allowed).
- sout changes only on step edges (and reset). Load/clear/hold do not modify it.
- amt > WIDTH is legal: rotates wrap, logical shifts fill with sin, ASR saturates to all-MSB.
- Idle with no command: q holds.

Decomposition:
- Package usr_pkg:
  - Opcode localparams OP_HOLD..OP_ASR.
  - FSM state encoding (IDLE, STEP).
  - Function returning the exiting bit per op.
- Sub-module usr_step: combinational next-value unit (op, q, sin -> q_next, bit_out). Reused by the FSM for every step.
- Top module holds q, sout, count, the latched op, and the FSM.

Test Plan (WIDTH=8, CNT_W=4):
- Reset: drive reset=0 between clock edges -> q=00, busy=0, done=0, sout=0 immediately. Release, no command -> q stays 00.
- Legacy load and priority:
  - ld=1, d=A5 -> q=A5 next edge, no done pulse.
  - ld=1 with start=1, op=CLEAR -> q=00, done pulse.
- SLL: q=A5, start op=SLL amt=3 sin=1 -> q=4B,97,2F on E1..E3; busy high 3 cycles; done one cycle after E3; sout=1.
- Rotate/arith:
  - q=01, ROR amt=1 -> 80, sout=1.
  - q=3C, ROL amt=8 -> 3C.
  - q=90, ASR amt=2 -> C8 then E4, sout=0.
- Edge cases:
  - amt=0 SRL -> q unchanged, done pulse, busy never high.
  - start during busy -> ignored.
  - Back-to-back start in the done cycle -> accepted.
- Reset mid-op: q=FF, SLL amt=5 sin=0; assert reset after E2 -> q=00, busy=0, done=0 at once. After release, a new command executes normally.
